// File: rtl/floo_vc_credit_scheduler_pkg.sv
// Shared types and helpers for the VC credit path.
// The downstream credit-return block reuses these same types and helpers.
package floo_vc_credit_scheduler_pkg;

  // Lock state of the packet-level scheduler.
  // Idle: no packet is open. Locked: a packet is open on one VC.
  typedef enum logic [0:0] {
    Idle   = 1'b0,
    Locked = 1'b1
  } vc_sched_state_e;

  // Counter width that can hold every value from 0 to num_credits.
  function automatic int unsigned cnt_width(input int unsigned num_credits);
    return $clog2(num_credits + 32'd1);
  endfunction

  // Width of a VC index. A single VC still gets a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned num_vcs);
    return (num_vcs > 32'd1) ? $clog2(num_vcs) : 32'd1;
  endfunction

  localparam int unsigned DefaultNumCredits = 32'd4;
  localparam int unsigned DefaultCntWidth   = cnt_width(DefaultNumCredits);

  // Credit counter type for the default buffer depth.
  typedef logic [DefaultCntWidth-1:0] credit_cnt_t;

endpackage

// File: rtl/floo_vc_credit_scheduler_chk.sv
// Protocol checker for the VC credit scheduler. It holds only properties and no logic.
module floo_vc_credit_scheduler_chk #(
  parameter int unsigned NumVirtChannels = 32'd2
) (
  input logic                       clk_i,
  input logic                       rst_ni,
  input logic [NumVirtChannels-1:0] valid_i,
  input logic [NumVirtChannels-1:0] ready_i,
  input logic [NumVirtChannels-1:0] credit_i,
  input logic [NumVirtChannels-1:0] full_i,
  input logic [NumVirtChannels-1:0] empty_i
);

  // The link carries one flit per cycle, so at most one VC is granted.
  a_onehot_grant: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(ready_i))
    else $error("more than one VC granted in one cycle");

  for (genvar v = 0; v < NumVirtChannels; v++) begin : g_vc
    // Upstream keeps a pending request asserted until it is granted.
    a_valid_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (valid_i[v] && !ready_i[v]) |=> valid_i[v])
      else $error("valid dropped without grant on VC %0d", v);

    // Downstream returned more credits than its buffer can hold.
    a_credit_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(credit_i[v] && full_i[v] && !ready_i[v]))
      else $error("credit overflow on VC %0d", v);

    // A flit is never sent without a credit.
    a_grant_no_credit: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(ready_i[v] && empty_i[v]))
      else $error("grant without credit on VC %0d", v);
  end

endmodule

// File: rtl/floo_vc_credit_scheduler_credit_counter.sv
// Per-VC credit counter.
// Reset loads the full downstream buffer depth. A grant spends one credit and a
// returned credit adds one back. Both in the same cycle leave the count unchanged.
// An increment at the maximum saturates instead of wrapping.
module floo_vc_credit_scheduler_credit_counter
  import floo_vc_credit_scheduler_pkg::*;
#(
  parameter int unsigned NumCredits = 32'd4,
  localparam int unsigned CntWidth  = cnt_width(NumCredits)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                dec_i,
  input  logic                inc_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                empty_o,
  output logic                full_o
);

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(NumCredits);
  localparam logic [CntWidth-1:0] One    = CntWidth'(32'd1);
  localparam logic [CntWidth-1:0] Zero   = CntWidth'(32'd0);

  logic [CntWidth-1:0] cnt_d;
  logic [CntWidth-1:0] cnt_q;

  // Next credit count: spend on grant, refill on a returned credit, clamp at both ends.
  always_comb begin
    cnt_d = cnt_q;
    case ({dec_i, inc_i})
      2'b10: begin
        if (cnt_q != Zero) begin
          cnt_d = cnt_q - One;
        end else begin
          cnt_d = cnt_q;
        end
      end
      2'b01: begin
        if (cnt_q != MaxCnt) begin
          cnt_d = cnt_q + One;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Credit register. Reset gives the full downstream buffer depth.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= MaxCnt;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign empty_o = (cnt_q == Zero);
  assign full_o  = (cnt_q == MaxCnt);

endmodule

// File: rtl/floo_vc_credit_scheduler.sv
// VC credit scheduler at a router output port.
// Several VCs share one physical link. Per-VC credit counters replace ready-based
// backpressure on the link. Scheduling is round-robin per packet. Once the head flit
// of a packet is granted, its VC holds the link until the tail flit, so packets are
// never interleaved.
module floo_vc_credit_scheduler
  import floo_vc_credit_scheduler_pkg::*;
#(
  parameter int unsigned NumVirtChannels = 32'd2,
  parameter int unsigned NumCredits      = 32'd4,
  parameter type         flit_t          = logic,
  localparam int unsigned CntWidth       = cnt_width(NumCredits),
  localparam int unsigned IdxWidth       = idx_width(NumVirtChannels)
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic  [NumVirtChannels-1:0]              valid_i,
  output logic  [NumVirtChannels-1:0]              ready_o,
  input  logic  [NumVirtChannels-1:0]              last_i,
  input  flit_t [NumVirtChannels-1:0]              data_i,
  output logic                                     valid_o,
  output logic  [IdxWidth-1:0]                     vc_id_o,
  output flit_t                                    data_o,
  input  logic  [NumVirtChannels-1:0]              credit_i,
  output logic  [NumVirtChannels-1:0][CntWidth-1:0] credit_cnt_o
);

  localparam logic [IdxWidth:0]   NumVcExt = (IdxWidth+1)'(NumVirtChannels);
  localparam logic [IdxWidth-1:0] LastIdx  = IdxWidth'(NumVirtChannels - 32'd1);
  localparam logic [IdxWidth-1:0] IdxOne   = IdxWidth'(32'd1);
  localparam logic [IdxWidth-1:0] IdxZero  = IdxWidth'(32'd0);

  logic [NumVirtChannels-1:0] empty_s;
  logic [NumVirtChannels-1:0] full_s;
  logic [NumVirtChannels-1:0] eligible_s;
  logic [NumVirtChannels-1:0] grant_s;
  logic                       grant_valid_s;
  logic [IdxWidth-1:0]        grant_idx_s;

  vc_sched_state_e            state_q;
  logic [IdxWidth-1:0]        lock_vc_q;
  logic [IdxWidth-1:0]        rr_q;
  logic                       valid_q;
  logic [IdxWidth-1:0]        vc_id_q;
  flit_t                      data_q;

  // One credit counter per VC. A grant spends a credit and credit_i returns one.
  for (genvar v = 0; v < NumVirtChannels; v++) begin : g_cnt
    floo_vc_credit_scheduler_credit_counter #(
      .NumCredits (NumCredits)
    ) i_credit_counter (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .dec_i   (grant_s[v]),
      .inc_i   (credit_i[v]),
      .cnt_o   (credit_cnt_o[v]),
      .empty_o (empty_s[v]),
      .full_o  (full_s[v])
    );
  end

  // Eligibility uses only the registered credit count. A credit that arrives in the
  // same cycle cannot unblock a VC until the next cycle.
  assign eligible_s = valid_i & ~empty_s;

  // Grant selection.
  // Locked: only the locked VC may go.
  // Idle: take the first eligible VC at or after the round-robin pointer, wrapping.
  always_comb begin
    logic [IdxWidth:0] sum_v;
    grant_valid_s = 1'b0;
    grant_idx_s   = IdxZero;
    sum_v         = '0;
    case (state_q)
      Locked: begin
        if (eligible_s[lock_vc_q]) begin
          grant_valid_s = 1'b1;
          grant_idx_s   = lock_vc_q;
        end else begin
          grant_valid_s = 1'b0;
          grant_idx_s   = lock_vc_q;
        end
      end
      Idle: begin
        for (int unsigned i = 0; i < NumVirtChannels; i++) begin
          sum_v = {1'b0, rr_q} + (IdxWidth+1)'(i);
          if (sum_v >= NumVcExt) begin
            sum_v = sum_v - NumVcExt;
          end else begin
            sum_v = sum_v;
          end
          if (!grant_valid_s && eligible_s[sum_v[IdxWidth-1:0]]) begin
            grant_valid_s = 1'b1;
            grant_idx_s   = sum_v[IdxWidth-1:0];
          end else begin
            grant_valid_s = grant_valid_s;
          end
        end
      end
      default: begin
        grant_valid_s = 1'b0;
        grant_idx_s   = IdxZero;
      end
    endcase
  end

  // Convert the granted index to the one-hot ready vector.
  always_comb begin
    grant_s = '0;
    if (grant_valid_s) begin
      grant_s[grant_idx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  assign ready_o = grant_s;

  // Lock FSM, round-robin pointer and link output register.
  // A head flit without last_i locks the link to its VC. A tail flit unlocks the link
  // and moves the pointer past the VC that just finished.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= Idle;
      lock_vc_q <= IdxZero;
      rr_q      <= IdxZero;
      valid_q   <= 1'b0;
      vc_id_q   <= IdxZero;
      data_q    <= '0;
    end else begin
      valid_q <= grant_valid_s;
      if (grant_valid_s) begin
        vc_id_q <= grant_idx_s;
        data_q  <= data_i[grant_idx_s];
        case (state_q)
          Idle, Locked: begin
            if (last_i[grant_idx_s]) begin
              state_q <= Idle;
              rr_q    <= (grant_idx_s == LastIdx) ? IdxZero : grant_idx_s + IdxOne;
            end else begin
              state_q   <= Locked;
              lock_vc_q <= grant_idx_s;
            end
          end
          default: state_q <= Idle;
        endcase
      end else begin
        vc_id_q <= vc_id_q;
        data_q  <= data_q;
      end
    end
  end

  assign valid_o = valid_q;
  assign vc_id_o = (NumVirtChannels == 32'd1) ? IdxZero : vc_id_q;
  assign data_o  = data_q;

  floo_vc_credit_scheduler_chk #(
    .NumVirtChannels (NumVirtChannels)
  ) i_chk (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .ready_i  (grant_s),
    .credit_i (credit_i),
    .full_i   (full_s),
    .empty_i  (empty_s)
  );

endmodule
